mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin scheduler that shares a single global-memory channel among NUM_CONSUMERS requesters (fetchers or LSUs). It uses the same valid/ready request protocol as the memory controller. Grants rotate strictly so that no consumer starves. It sits between core-side consumers and one memory port, for configurations with one channel where fairness matters more than concurrency.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 16, data width
- NUM_CONSUMERS, 4, requester count (≥1); ID width IDW = max(1, $clog2(NUM_CONSUMERS))
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT states (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- consumer_read_valid  in  [NUM_CONSUMERS]  read request, held until ready seen
- consumer_read_address  in  [ADDR_BITS] x NUM_CONSUMERS  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read done; data valid while high
- consumer_read_data  out  [DATA_BITS] x NUM_CONSUMERS  returned data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request
- consumer_write_address  in  [ADDR_BITS] x NUM_CONSUMERS  write address
- consumer_write_data  in  [DATA_BITS] x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write done
- mem_read_valid  out  1; mem_read_address  out  ADDR_BITS; mem_read_ready  in  1; mem_read_data  in  DATA_BITS
- mem_write_valid  out  1; mem_write_address  out  ADDR_BITS; mem_write_data  out  DATA_BITS; mem_write_ready  in  1
- grant_id  out  IDW  consumer currently owning the channel
- busy  out  1  high in any state other than IDLE
- timeout_error  out  1  sticky watchdog flag (present only with MEM_ARB_TIMEOUT_EN)

## Operation
- States: IDLE, WAIT_READ, WAIT_WRITE, RELAY_READ, RELAY_WRITE.
- Reset values: all outputs 0, consumer_read_data all 0, rr_ptr 0, state IDLE.
- IDLE: scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS. The first consumer with read_valid or write_valid wins.
  - If the winner has both read_valid and write_valid, the read is served. The write is served on a later grant.
  - On grant: grant_id ← winner; rr_ptr ← winner+1, wrapping to 0 at NUM_CONSUMERS (correct for non-power-of-two counts).
  - Read grant: mem_read_valid ← 1, mem_read_address ← that consumer's address, state → WAIT_READ.
  - Write grant: drive the mem_write_* outputs, state → WAIT_WRITE.
- WAIT_READ: when mem_read_ready is sampled high:
  - mem_read_valid ← 0
  - consumer_read_data[grant_id] ← mem_read_data
  - consumer_read_ready[grant_id] ← 1
  - state → RELAY_READ
- WAIT_WRITE: when mem_write_ready is sampled high, mem_write_valid ← 0, consumer_write_ready[grant_id] ← 1, state → RELAY_WRITE.
- RELAY_*: when the granted consumer's matching valid is sampled low, its ready ← 0 and state → IDLE.
- consumer_read_data holds its value until the next read completion for that consumer.
- Address and data are captured at grant. Consumer input changes after grant are ignored.
- A consumer dropping valid during WAIT (protocol violation): the memory transaction still completes and the relay still happens. RELAY then exits on the next edge.
- No request pending in IDLE: no output changes, rr_ptr unchanged.

## Timing
- Grant decision is made from inputs sampled at edge E0. mem_*_valid is high after E0.
- If mem ready is high at E1, consumer ready is high after E1. This is 1-cycle arbitration latency plus the memory latency.
- The consumer drops valid, seen at E2. Ready is low after E2. The earliest next grant is at E3, giving a minimum of 3 cycles per transaction.
- Only one mem_*_valid is ever high. At most one consumer ready bit is high.
- Reset asserted mid-transaction clears everything asynchronously. The in-flight memory request is abandoned.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entering WAIT_* and increments each cycle without ready.
  - When the count reaches TIMEOUT_CYCLES, the arbiter acts as if ready arrived: mem valid ← 0, consumer ready ← 1, read data ← 0, and timeout_error ← 1.
  - timeout_error stays high until reset. A real ready in the same cycle takes precedence and sets no error.
- MEM_ARB_TIMEOUT_EN undefined: WAIT states wait indefinitely. There is no counter and no timeout_error port.

## Structure
- Package mem_arb_pkg holds the arb_state_t enum for the five states, with IDLE = 0.
- The sub-module rr_picker is combinational. Inputs are a request vector and a pointer; outputs are found and the winner index.
- rr_picker is reused by later dispatch logic.

## Test plan
- Single consumer 2 reads addr 0x10, mem returns 0x1234 after 2 cycles → consumer_read_data[2] = 0x1234, ready high one cycle after mem ready, mem_read_address = 0x10.
- All 4 consumers hold read_valid continuously → grant_id sequence 0,1,2,3,0; no repeats before all are served.
- Consumer 1 asserts read and write together (write addr 0x20, data 0xBEEF) → read served first. Write is granted on a later turn with mem_write_data = 0xBEEF.
- NUM_CONSUMERS = 3, consumer 2 granted → rr_ptr wraps to 0. The next grant goes to consumer 0 when 0 and 1 both request.
- Reset asserted during WAIT_READ → all outputs 0 immediately, busy 0. The first request after release is granted from consumer 0 upward.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, memory never responds → consumer ready after 4 WAIT cycles with data 0, and timeout_error stays at 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the round-robin memory arbiter and its picker.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_READ   = 3'd1,
    WAIT_WRITE  = 3'd2,
    RELAY_READ  = 3'd3,
    RELAY_WRITE = 3'd4
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  function automatic int wrap_add(input int p, input int i);
    return (p + i >= N) ? (p + i - N) : (p + i);
  endfunction

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[wrap_add(int'(ptr_i), i)]) begin
        found_o = 1'b1;
        idx_o   = IDW'(wrap_add(int'(ptr_i), i));
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory channel among NUM_CONSUMERS requesters.
// Optional watchdog on WAIT states enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready,
  output logic [id_width(NUM_CONSUMERS)-1:0]      grant_id,
  output logic                                    busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                                    timeout_error
`endif
);

  localparam int N   = NUM_CONSUMERS;
  localparam int IDW = id_width(NUM_CONSUMERS);

  arb_state_t                  state_q, state_d;
  logic [IDW-1:0]              grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic                        mem_rv_q, mem_rv_d, mem_wv_q, mem_wv_d;
  logic [ADDR_BITS-1:0]        mem_ra_q, mem_ra_d, mem_wa_q, mem_wa_d;
  logic [DATA_BITS-1:0]        mem_wd_q, mem_wd_d;
  logic [N-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [N-1:0]                rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic                        found;
  logic [IDW-1:0]              win;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          expire;
  // Fires on the cycle whose increment would bring the count to the limit.
  assign expire = (cnt_q + 1'b1) == CW'(TIMEOUT_CYCLES);
  assign timeout_error = err_q;
`endif

  rr_picker #(.N(N), .IDW(IDW)) u_picker (
    .req_i   (consumer_read_valid | consumer_write_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (found),
    .idx_o   (win)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    mem_rv_d  = mem_rv_q;
    mem_wv_d  = mem_wv_q;
    mem_ra_d  = mem_ra_q;
    mem_wa_d  = mem_wa_q;
    mem_wd_d  = mem_wd_q;
    rd_data_d = rd_data_q;
    rd_rdy_d  = rd_rdy_q;
    wr_rdy_d  = wr_rdy_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = win;
          rr_ptr_d = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
          // Read wins when a consumer presents both; its write waits for a later turn.
          if (consumer_read_valid[win]) begin
            mem_rv_d = 1'b1;
            mem_ra_d = consumer_read_address[win];
            state_d  = WAIT_READ;
          end else begin
            mem_wv_d = 1'b1;
            mem_wa_d = consumer_write_address[win];
            mem_wd_d = consumer_write_data[win];
            state_d  = WAIT_WRITE;
          end
        end
      end
      WAIT_READ: begin
        if (mem_read_ready) begin
          mem_rv_d           = 1'b0;
          rd_data_d[grant_q] = mem_read_data;
          rd_rdy_d[grant_q]  = 1'b1;
          state_d            = RELAY_READ;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expire) begin
          mem_rv_d           = 1'b0;
          rd_data_d[grant_q] = '0;
          rd_rdy_d[grant_q]  = 1'b1;
          err_d              = 1'b1;
          state_d            = RELAY_READ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_WRITE: begin
        if (mem_write_ready) begin
          mem_wv_d          = 1'b0;
          wr_rdy_d[grant_q] = 1'b1;
          state_d           = RELAY_WRITE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expire) begin
          mem_wv_d          = 1'b0;
          wr_rdy_d[grant_q] = 1'b1;
          err_d             = 1'b1;
          state_d           = RELAY_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELAY_READ: begin
        if (!consumer_read_valid[grant_q]) begin
          rd_rdy_d[grant_q] = 1'b0;
          state_d           = IDLE;
        end
      end
      RELAY_WRITE: begin
        if (!consumer_write_valid[grant_q]) begin
          wr_rdy_d[grant_q] = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      mem_rv_q  <= 1'b0;
      mem_wv_q  <= 1'b0;
      mem_ra_q  <= '0;
      mem_wa_q  <= '0;
      mem_wd_q  <= '0;
      rd_data_q <= '0;
      rd_rdy_q  <= '0;
      wr_rdy_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      mem_rv_q  <= mem_rv_d;
      mem_wv_q  <= mem_wv_d;
      mem_ra_q  <= mem_ra_d;
      mem_wa_q  <= mem_wa_d;
      mem_wd_q  <= mem_wd_d;
      rd_data_q <= rd_data_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_read_data   = rd_data_q;
  assign consumer_write_ready = wr_rdy_q;
  assign mem_read_valid       = mem_rv_q;
  assign mem_read_address     = mem_ra_q;
  assign mem_write_valid      = mem_wv_q;
  assign mem_write_address    = mem_wa_q;
  assign mem_write_data       = mem_wd_q;
  assign grant_id             = grant_q;
  assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a 4-consumer and a 3-consumer instance on one clock.
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]       crv, crr, cwv, cwr;
  logic [3:0][7:0]  cra, cwa;
  logic [3:0][15:0] crd, cwd;
  logic             mrv, mrr, mwv, mwr, busy;
  logic [7:0]       mra, mwa;
  logic [15:0]      mrd, mwd;
  logic [1:0]       gid;

  logic [2:0]       crv3, crr3, cwv3, cwr3;
  logic [2:0][7:0]  cra3, cwa3;
  logic [2:0][15:0] crd3, cwd3;
  logic             mrv3, mrr3, mwv3, mwr3, busy3;
  logic [7:0]       mra3, mwa3;
  logic [15:0]      mrd3, mwd3;
  logic [1:0]       gid3;

`ifdef MEM_ARB_TIMEOUT_EN
  logic terr, terr3;
`endif

  mem_rr_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd), .mem_write_ready(mwr),
    .grant_id(gid), .busy(busy)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_error(terr)
`endif
  );

  mem_rr_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(3), .TIMEOUT_CYCLES(4)) dut3 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(crv3), .consumer_read_address(cra3),
    .consumer_read_ready(crr3), .consumer_read_data(crd3),
    .consumer_write_valid(cwv3), .consumer_write_address(cwa3),
    .consumer_write_data(cwd3), .consumer_write_ready(cwr3),
    .mem_read_valid(mrv3), .mem_read_address(mra3), .mem_read_ready(mrr3), .mem_read_data(mrd3),
    .mem_write_valid(mwv3), .mem_write_address(mwa3), .mem_write_data(mwd3), .mem_write_ready(mwr3),
    .grant_id(gid3), .busy(busy3)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_error(terr3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         ng;
  logic [1:0] gseq [5];

  initial begin
    reset = 1'b1;
    crv = '0; cra = '0; cwv = '0; cwa = '0; cwd = '0;
    mrr = 1'b0; mrd = '0; mwr = 1'b0;
    crv3 = '0; cra3 = '0; cwv3 = '0; cwa3 = '0; cwd3 = '0;
    mrr3 = 1'b1; mrd3 = 16'h3333; mwr3 = 1'b1;
    tick(); tick();
    chk("rst_mrv", mrv, 0);
    chk("rst_mwv", mwv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_crd", crd, 0);
    chk("rst_rdy", {crr, cwr}, 0);
    reset = 1'b0;

    // Consumer 2 reads 0x10, memory answers after two cycles.
    crv[2] = 1'b1; cra[2] = 8'h10;
    tick();
    chk("t1_mrv", mrv, 1);
    chk("t1_mra", mra, 8'h10);
    chk("t1_gid", gid, 2);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_wait_crr", crr, 4'b0000);
    mrr = 1'b1; mrd = 16'h1234;
    tick();
    chk("t1_crr", crr, 4'b0100);
    chk("t1_crd2", crd[2], 16'h1234);
    chk("t1_mrv_low", mrv, 0);
    mrr = 1'b0; crv[2] = 1'b0;
    tick();
    chk("t1_crr_low", crr, 4'b0000);
    chk("t1_idle", busy, 0);

    // All four consumers requesting: grants must rotate 0,1,2,3,0.
    reset = 1'b1; tick(); reset = 1'b0;
    mrr = 1'b1; mrd = 16'h5A5A; crv = 4'hF; ng = 0;
    for (int t = 0; t < 60 && ng < 5; t++) begin
      tick();
      chk("t2_one_ready", ($countones(crr) <= 1), 1);
      if (mrv) begin
        gseq[ng] = gid;
        ng++;
      end
      crv = ~crr;
    end
    chk("t2_grants", ng, 5);
    chk("t2_g0", gseq[0], 0);
    chk("t2_g1", gseq[1], 1);
    chk("t2_g2", gseq[2], 2);
    chk("t2_g3", gseq[3], 3);
    chk("t2_g4", gseq[4], 0);
    crv = '0;
    tick();
    tick();
    mrr = 1'b0;
    chk("t2_crd0", crd[0], 16'h5A5A);
    chk("t2_idle", busy, 0);

    // Consumer 1 reads and writes together: read first, write on a later grant.
    crv = 4'b0010; cwv = 4'b0010; cra[1] = 8'h30; cwa[1] = 8'h20; cwd[1] = 16'hBEEF; mrd = 16'h0777;
    tick();
    chk("t3_rd_first", {mrv, mwv}, 2'b10);
    chk("t3_gid", gid, 1);
    chk("t3_mra", mra, 8'h30);
    mrr = 1'b1;
    tick();
    chk("t3_crr", crr, 4'b0010);
    chk("t3_crd1", crd[1], 16'h0777);
    mrr = 1'b0; crv = '0;
    tick();
    chk("t3_crr_low", crr, 4'b0000);
    tick();
    chk("t3_wr_grant", {mrv, mwv}, 2'b01);
    chk("t3_mwa", mwa, 8'h20);
    chk("t3_mwd", mwd, 16'hBEEF);
    chk("t3_wgid", gid, 1);
    cwd[1] = 16'h1111; cwa[1] = 8'hFF;
    tick();
    chk("t3_mwd_held", mwd, 16'hBEEF);
    chk("t3_mwa_held", mwa, 8'h20);
    chk("t3_cwr_wait", cwr, 4'b0000);
    mwr = 1'b1;
    tick();
    chk("t3_cwr", cwr, 4'b0010);
    chk("t3_mwv_low", mwv, 0);
    mwr = 1'b0; cwv = '0;
    tick();
    chk("t3_cwr_low", cwr, 4'b0000);
    chk("t3_idle", busy, 0);

    // Asynchronous reset while waiting on a read clears state and the pointer.
    cra[1] = 8'h44; crv = 4'b0010;
    tick();
    chk("t5_wait", {busy, mrv, gid}, 4'b1101);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_mrv", mrv, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_gid", gid, 0);
    chk("t5_async_crd", crd, 0);
    crv = '0;
    tick();
    reset = 1'b0;
    crv = 4'b1010;
    tick();
    chk("t5_regrant", gid, 1);
    chk("t5_regrant_mra", mra, 8'h44);
    mrr = 1'b1;
    tick();
    crv = '0; mrr = 1'b0;
    tick();
    chk("t5_idle", busy, 0);

    // Three consumers: grant to 2 wraps the pointer back to 0.
    crv3 = 3'b100;
    tick();
    chk("t4_gid2", gid3, 2);
    chk("t4_mrv", mrv3, 1);
    tick();
    chk("t4_crr", crr3, 3'b100);
    crv3 = '0;
    tick();
    cra3[0] = 8'h05; crv3 = 3'b011;
    tick();
    chk("t4_wrap_gid", gid3, 0);
    chk("t4_wrap_mra", mra3, 8'h05);
    tick();
    crv3 = '0;
    tick();
    chk("t4_idle", busy3, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Normal read to put nonzero data in slot 0, then a read the memory never answers.
    crv = 4'b0001; mrd = 16'hCAFE; mrr = 1'b1;
    tick(); tick();
    crv = '0; mrr = 1'b0;
    tick();
    chk("to_pre_crd0", crd[0], 16'hCAFE);
    chk("to_pre_err", terr, 0);
    crv = 4'b0001;
    tick();
    chk("to_grant", {mrv, gid}, 3'b100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_waiting", {crr[0], terr}, 2'b00);
    end
    tick();
    chk("to_crr", crr, 4'b0001);
    chk("to_crd0", crd[0], 16'h0000);
    chk("to_err", terr, 1);
    chk("to_mrv_low", mrv, 0);
    crv = '0;
    tick();
    chk("to_err_sticky", terr, 1);
    chk("to_idle", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
